// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: one-cold column strobes, frame-level debounce, chord rejection,
// optional auto-repeat and emit-on-release, one-cycle key events with a linear key code.
module keypad_scanner #(
  parameter int N_ROWS          = 4,
  parameter int N_COLS          = 4,
  parameter int SCAN_DIV        = 1,
  parameter int DEBOUNCE        = 2,
  parameter int EMIT_ON_RELEASE = 0,
  parameter int REPEAT_DLY      = 0,
  parameter int REPEAT_PER      = 2,
  localparam int CODE_W         = $clog2(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] fila,
  output logic [N_COLS-1:0] col,
  output logic [CODE_W-1:0] code,
  output logic              key_valid,
  output logic              key_down,
  output logic              multi_err
);

  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int RP_W  = $clog2(REPEAT_DLY + REPEAT_PER + 1);

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  localparam logic              EMIT_PRESS = (EMIT_ON_RELEASE == 0);
  localparam logic              REP_EN     = (REPEAT_DLY != 0) && (EMIT_ON_RELEASE == 0);
  localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE);
  localparam logic [RP_W-1:0]   RP_FIRST   = RP_W'(REPEAT_DLY);
  localparam logic [RP_W-1:0]   RP_WRAP    = RP_W'(REPEAT_DLY + REPEAT_PER);
  localparam logic [N_COLS-1:0] COL0_COLD  = ~{{(N_COLS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [N_COLS-1:0] col_q, col_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        res_kind_q, res_kind_d;
  logic [CODE_W-1:0] res_code_q, res_code_d;

  logic [N_ROWS-1:0] hit_s;
  logic [1:0]        col_cnt_s;
  logic [ROW_W-1:0]  col_row_s;
  logic              col_any_s;
  logic [CODE_W-1:0] col_code_s;
  logic [2:0]        sum_s;
  logic [1:0]        merged_cnt_s;
  logic [CODE_W-1:0] merged_code_s;
  logic              dwell_end_s;
  logic              wrap_s;

  state_t            state_q;
  logic [DB_W-1:0]   cnt_q;
  logic [CODE_W-1:0] cand_q;
  logic [CODE_W-1:0] code_q;
  logic [RP_W-1:0]   rep_q;
  logic              key_valid_q;
  logic              key_down_q;
  logic              multi_err_q;
  logic [DB_W-1:0]   cnt_inc_s;
  logic [RP_W-1:0]   rep_inc_s;

  assign cnt_inc_s = cnt_q + DB_W'(1);
  assign rep_inc_s = rep_q + RP_W'(1);

  // Lowest pressed row wins inside a column; hit count saturates at 2 (only "more than one" matters).
  always_comb begin
    hit_s     = ~fila;
    col_cnt_s = 2'd0;
    col_row_s = {ROW_W{1'b0}};
    col_any_s = 1'b0;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      col_cnt_s = (hit_s[r] && (col_cnt_s != 2'd2)) ? col_cnt_s + 2'd1 : col_cnt_s;
      col_row_s = hit_s[r] ? ROW_W'(r) : col_row_s;
      col_any_s = col_any_s | hit_s[r];
    end
    col_code_s    = CODE_W'(col_row_s) * CODE_W'(N_COLS) + CODE_W'(col_idx_q);
    sum_s         = {1'b0, acc_cnt_q} + {1'b0, col_cnt_s};
    merged_cnt_s  = (sum_s >= 3'd2) ? RES_MULTI : sum_s[1:0];
    merged_code_s = ((acc_cnt_q == 2'd0) && col_any_s) ? col_code_s : acc_code_q;
  end

  // Column dwell divider, column advance and per-frame accumulation.
  always_comb begin
    dwell_end_s = (div_q == DIV_W'(SCAN_DIV - 1));
    wrap_s      = dwell_end_s && (col_idx_q == COL_W'(N_COLS - 1));
    div_d       = div_q;
    col_idx_d   = col_idx_q;
    col_d       = col_q;
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    res_valid_d = 1'b0;
    res_kind_d  = res_kind_q;
    res_code_d  = res_code_q;
    if (!dwell_end_s) begin
      div_d = div_q + DIV_W'(1);
    end else if (wrap_s) begin
      div_d       = {DIV_W{1'b0}};
      col_idx_d   = {COL_W{1'b0}};
      col_d       = COL0_COLD;
      acc_cnt_d   = 2'd0;
      acc_code_d  = {CODE_W{1'b0}};
      res_valid_d = 1'b1;
      res_kind_d  = merged_cnt_s;
      res_code_d  = merged_code_s;
    end else begin
      div_d      = {DIV_W{1'b0}};
      col_idx_d  = col_idx_q + COL_W'(1);
      col_d      = {col_q[N_COLS-2:0], 1'b1};
      acc_cnt_d  = merged_cnt_s;
      acc_code_d = merged_code_s;
    end
  end

  // Scanner state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= {DIV_W{1'b0}};
      col_idx_q   <= {COL_W{1'b0}};
      col_q       <= COL0_COLD;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= {CODE_W{1'b0}};
      res_valid_q <= 1'b0;
      res_kind_q  <= RES_NONE;
      res_code_q  <= {CODE_W{1'b0}};
    end else begin
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      res_valid_q <= res_valid_d;
      res_kind_q  <= res_kind_d;
      res_code_q  <= res_code_d;
    end
  end

  // Debounce/hold FSM: advances once per registered frame result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {DB_W{1'b0}};
      cand_q      <= {CODE_W{1'b0}};
      code_q      <= {CODE_W{1'b0}};
      rep_q       <= {RP_W{1'b0}};
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
      if (res_valid_q) begin
        case (state_q)
          IDLE: begin
            case (res_kind_q)
              RES_SINGLE: begin
                if (DB_ONE == DB_LAST) begin
                  state_q     <= PRESSED;
                  key_down_q  <= 1'b1;
                  code_q      <= res_code_q;
                  rep_q       <= {RP_W{1'b0}};
                  key_valid_q <= EMIT_PRESS;
                end else begin
                  state_q <= DB_PRESS;
                  cand_q  <= res_code_q;
                  cnt_q   <= DB_ONE;
                end
              end
              RES_MULTI: multi_err_q <= 1'b1;
              default:   state_q     <= IDLE;
            endcase
          end
          DB_PRESS: begin
            case (res_kind_q)
              RES_SINGLE: begin
                if (res_code_q != cand_q) begin
                  cand_q <= res_code_q;
                  cnt_q  <= DB_ONE;
                end else if (cnt_inc_s == DB_LAST) begin
                  state_q     <= PRESSED;
                  key_down_q  <= 1'b1;
                  code_q      <= cand_q;
                  rep_q       <= {RP_W{1'b0}};
                  key_valid_q <= EMIT_PRESS;
                end else begin
                  cnt_q <= cnt_inc_s;
                end
              end
              RES_MULTI: begin
                multi_err_q <= 1'b1;
                state_q     <= IDLE;
              end
              default: state_q <= IDLE;
            endcase
          end
          PRESSED: begin
            if (res_kind_q == RES_NONE) begin
              if (DB_ONE == DB_LAST) begin
                state_q     <= IDLE;
                key_down_q  <= 1'b0;
                key_valid_q <= !EMIT_PRESS;
              end else begin
                state_q <= DB_REL;
                cnt_q   <= DB_ONE;
              end
            end else if (REP_EN) begin
              // After the first repeat the counter folds back so later repeats come every REPEAT_PER frames.
              if (rep_inc_s == RP_WRAP) begin
                rep_q       <= RP_FIRST;
                key_valid_q <= 1'b1;
              end else begin
                rep_q       <= rep_inc_s;
                key_valid_q <= (rep_inc_s == RP_FIRST);
              end
            end
          end
          DB_REL: begin
            if (res_kind_q != RES_NONE) begin
              state_q <= PRESSED;
            end else if (cnt_inc_s == DB_LAST) begin
              state_q     <= IDLE;
              key_down_q  <= 1'b0;
              key_valid_q <= !EMIT_PRESS;
            end else begin
              cnt_q <= cnt_inc_s;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign code      = code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign multi_err = multi_err_q;

endmodule
